// File: rtl/lu_serial_sequencer.sv
// lu_serial_sequencer: bit-serial front/back end for a 1-bit logic unit
// (XOR/XNOR/OR/NOR). It accepts an operand set, streams one bit pair per
// clock LSB first, collects the returned bits and presents the WIDTH-bit
// result over a valid/ready handshake.
// Optional macro LU_SEQ_CHECK_EN adds an internal model that compares the
// collected result on entry to HOLD and raises a sticky err flag.
module lu_serial_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op_sel,
  output logic             lu_a,
  output logic             lu_b,
  output logic [1:0]       lu_sel,
  input  logic             lu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       sel_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             last_shift;

  // Next result value: shift right and insert the returned bit at the MSB,
  // so the first (LSB) bit ends up at position 0 after WIDTH shifts.
  always_comb begin
    res_d            = res_q >> 1;
    res_d[WIDTH-1]   = lu_out;
  end

  assign last_shift = (state_q == SHIFT) && (cnt_q == LAST);

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= op_a;
            b_q        <= op_b;
            sel_q      <= op_sel;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign lu_a      = (state_q == SHIFT) ? a_q[0] : 1'b0;
  assign lu_b      = (state_q == SHIFT) ? b_q[0] : 1'b0;
  assign lu_sel    = (state_q == SHIFT) ? sel_q  : 2'b00;

`ifdef LU_SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic             err_q;

  function automatic logic [WIDTH-1:0] lu_model(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       s);
    logic [WIDTH-1:0] r;
    case (s)
      2'b00:   r = a ^ b;
      2'b01:   r = ~(a ^ b);
      2'b10:   r = a | b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  // Expected result captured at acceptance; compared against the value
  // being loaded into res_q on the edge that enters HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && in_valid) begin
        exp_q <= lu_model(op_a, op_b, op_sel);
      end
      if (last_shift && (res_d != exp_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lu_serial_sequencer.sv
// Scoreboard bench for lu_serial_sequencer (WIDTH=4 plus a WIDTH=1 instance).
// Stimulus pushes expected results into a queue; a negedge monitor pops and
// compares whenever the DUT presents a result.
module tb_lu_serial_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic [1:0]   op_sel;
  logic         lu_a, lu_b, lu_out;
  logic [1:0]   lu_sel;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         err;
  logic         inj;

  logic         in_valid1, in_ready1, op_a1, op_b1, lu_a1, lu_b1, lu_out1;
  logic [1:0]   op_sel1, lu_sel1;
  logic         out_valid1, out_ready1, err1;
  logic [0:0]   result1;
  logic [0:0]   a1v, b1v;

  int           errors = 0;
  int           checks = 0;
  int unsigned  cyc = 0;
  int           rmode = 0;
  logic         exp_err = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  acc;
  } exp_t;
  exp_t q[$];

  lu_serial_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .lu_a(lu_a), .lu_b(lu_b),
    .lu_sel(lu_sel), .lu_out(lu_out), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .err(err)
  );

  lu_serial_sequencer #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(a1v), .op_b(b1v), .op_sel(op_sel1), .lu_a(lu_a1), .lu_b(lu_b1),
    .lu_sel(lu_sel1), .lu_out(lu_out1), .out_valid(out_valid1),
    .out_ready(out_ready1), .result(result1), .err(err1)
  );

  assign a1v = op_a1;
  assign b1v = op_b1;

  // 1-bit logic unit attached to each sequencer; inj flips the WIDTH=4 one.
  function automatic logic lu_bit(input logic a, input logic b, input logic [1:0] s);
    case (s)
      2'b00:   return a ^ b;
      2'b01:   return ~(a ^ b);
      2'b10:   return a | b;
      default: return ~(a | b);
    endcase
  endfunction

  assign lu_out  = lu_bit(lu_a, lu_b, lu_sel) ^ inj;
  assign lu_out1 = lu_bit(lu_a1, lu_b1, lu_sel1);

  // Word-level reference model.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] s);
    case (s)
      2'b00:   return a ^ b;
      2'b01:   return ~(a ^ b);
      2'b10:   return a | b;
      default: return ~(a | b);
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Consumer-side ready: 0 = stall, 1 = always ready, otherwise random.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares every presented result against the queue head.
  logic         prev_v = 1'b0;
  logic         hs_prev = 1'b0;
  logic [W-1:0] held = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_v  = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        chk("in_ready_after_hs", in_ready, 1);
        chk("out_valid_drop", out_valid, 0);
      end
      if (out_valid) begin
        if (!prev_v) begin
          if (q.size() == 0) begin
            chk("unexpected_result", q.size(), 1);
          end else begin
            chk("result", result, q[0].res);
            chk("latency", cyc - q[0].acc, W);
            chk("err", err, exp_err);
            held = result;
          end
        end
        chk("result_stable", result, held);
        chk("in_ready_in_hold", in_ready, 0);
        if (out_ready && q.size() > 0) void'(q.pop_front());
      end
      hs_prev = out_valid && out_ready;
      prev_v  = out_valid && !out_ready;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] s, input logic [W-1:0] exp, input bit gap);
    bit          done = 0;
    bit          rdy;
    int unsigned c;
    @(posedge clk); #1;
    if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1; op_a = a; op_b = b; op_sel = s;
    for (int i = 0; i < 300 && !done; i++) begin
      rdy = in_ready;
      c   = cyc;
      @(posedge clk);
      if (rdy) begin
        q.push_back('{exp, c + 1});
        done = 1;
      end
      #1;
    end
    chk("accept_timeout", 32'(done), 1);
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); op_sel = 2'($urandom);
    @(negedge clk);
    chk("in_ready_busy", in_ready, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sel = '0; inj = 1'b0;
    out_ready = 1'b0;
    in_valid1 = 1'b0; op_a1 = 1'b0; op_b1 = 1'b0; op_sel1 = '0; out_ready1 = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_lu", {lu_a, lu_b, lu_sel}, 0);
    chk("rst_err", err, 0);
    @(negedge clk); reset = 1'b0;

    // Fixed operands for each op code.
    rmode = 1;
    send(4'b1100, 4'b1010, 2'b00, 4'b0110, 0);
    send(4'b1100, 4'b1010, 2'b01, 4'b1001, 0);
    send(4'b1100, 4'b1010, 2'b10, 4'b1110, 0);
    send(4'b1100, 4'b1010, 2'b11, 4'b0001, 0);
    drain();

    // Every operand pair for every op code, random consumer back-pressure.
    rmode = 2;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          send(W'(a), W'(b), 2'(s), model(W'(a), W'(b), 2'(s)), 0);
    drain();

    // Stall in HOLD while new operands are offered; they must be ignored.
    rmode = 0;
    send(4'b0011, 4'b0101, 2'b10, model(4'b0011, 4'b0101, 2'b10), 0);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = out_valid;
      end
      chk("hold_timeout", 32'(seen), 1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom); op_sel = 2'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rmode = 1;
    drain();
    repeat (3) @(negedge clk);
    chk("no_spurious_accept", out_valid, 0);

    // Random operands with random gaps and back-pressure.
    rmode = 2;
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a, b;
      logic [1:0]   s;
      a = W'($urandom); b = W'($urandom); s = 2'($urandom);
      send(a, b, s, model(a, b, s), 1);
    end
    rmode = 1;
    drain();

`ifdef LU_SEQ_CHECK_EN
    // Corrupt bit 2 from the logic unit; err must set and stay set.
    exp_err = 1'b1;
    send(4'b1100, 4'b1010, 2'b00, 4'b0110 ^ 4'b0100, 0);
    @(posedge clk);
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    drain();
    send(4'b1111, 4'b0001, 2'b01, model(4'b1111, 4'b0001, 2'b01), 0);
    drain();
    chk("err_sticky", err, 1);
`endif

    // Reset during the second SHIFT cycle aborts the operation.
    rmode = 1;
    send(4'b0110, 4'b1001, 2'b00, 4'b1111, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    exp_err = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_lu", {lu_a, lu_b, lu_sel}, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_err", err, 0);
    @(negedge clk); reset = 1'b0;
    send(4'b1111, 4'b0000, 2'b10, 4'b1111, 0);
    drain();

    // WIDTH=1 instance: one SHIFT cycle, result after two edges.
    @(posedge clk); #1;
    chk("w1_in_ready", in_ready1, 1);
    in_valid1 = 1'b1; op_a1 = 1'b1; op_b1 = 1'b1; op_sel1 = 2'b11;
    @(posedge clk); #1;
    in_valid1 = 1'b0; op_a1 = 1'b0; op_b1 = 1'b0; op_sel1 = 2'b00;
    @(negedge clk);
    chk("w1_shift_valid", out_valid1, 0);
    chk("w1_shift_lu", {lu_a1, lu_b1, lu_sel1}, 4'b1111);
    @(negedge clk);
    chk("w1_out_valid", out_valid1, 1);
    chk("w1_result", result1, 0);
    out_ready1 = 1'b1;
    @(posedge clk); #1 out_ready1 = 1'b0;
    @(negedge clk);
    chk("w1_in_ready_after", in_ready1, 1);
    chk("w1_err", err1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
